// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver, byte FIFO, scan-code decoder and held-key table.
// Optional build macro KEY_TYPEMATIC_FILTER_EN drops auto-repeat makes of held keys.
module ps2_key_tracker #(
   parameter int FIFO_DEPTH  = 8,
   parameter int MAX_KEYS    = 6,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         ps2_clk,
   input  logic                         ps2_data,
   output logic                         ev_valid,
   input  logic                         ev_ready,
   output logic [7:0]                   ev_code,
   output logic                         ev_ext,
   output logic                         ev_break,
   output logic [$clog2(MAX_KEYS+1)-1:0] held_count,
   output logic                         shift,
   output logic                         ctrl,
   output logic                         alt,
   output logic                         caps,
   output logic                         overflow,
   output logic                         frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(MAX_KEYS+1);
   localparam int TW = $clog2(TIMEOUT_CYC+1);
   localparam int IW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

`ifdef KEY_TYPEMATIC_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, EMIT} st_t;

   // synchronisers: both lines see three flops; kc_q only remembers the last clock level
   logic [2:0]    kc_s;
   logic [2:0]    kd_s;
   logic          kc_q;
   logic          fall;
   logic          bit_d;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         kc_s <= '0;
         kd_s <= '0;
         kc_q <= 1'b0;
      end else begin
         kc_s <= {kc_s[1:0], ps2_clk};
         kd_s <= {kd_s[1:0], ps2_data};
         kc_q <= kc_s[2];
      end
   end

   assign fall  = kc_q & ~kc_s[2];
   assign bit_d = kd_s[2];

   logic [3:0]    bit_cnt;
   logic [7:0]    sr;
   logic [7:0]    rx_byte;
   logic          par_ok;
   logic          wr_en;
   logic [TW-1:0] idle_cnt;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bit_cnt   <= '0;
         sr        <= '0;
         rx_byte   <= '0;
         par_ok    <= 1'b0;
         wr_en     <= 1'b0;
         idle_cnt  <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         wr_en     <= 1'b0;
         if (fall) begin
            idle_cnt <= '0;
            unique case (bit_cnt)
               4'd0: begin
                  if (!bit_d) bit_cnt <= 4'd1;
                  else        frame_err <= 1'b1;
               end
               4'd9: begin
                  par_ok  <= ^{sr, bit_d};
                  bit_cnt <= 4'd10;
               end
               4'd10: begin
                  bit_cnt <= '0;
                  rx_byte <= sr;
                  if (bit_d && par_ok) wr_en     <= 1'b1;
                  else                 frame_err <= 1'b1;
               end
               default: begin
                  sr      <= {bit_d, sr[7:1]};
                  bit_cnt <= bit_cnt + 4'd1;
               end
            endcase
         end else if (bit_cnt != 4'd0) begin
            if (idle_cnt == TW'(TIMEOUT_CYC)) begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;
   logic        full;
   logic        empty;
   logic        rd;
   logic        wr_ok;
   logic [7:0]  head;
   st_t         st;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign rd    = (st != EMIT) && !empty;
   assign wr_ok = wr_en && (!full || rd);
   assign head  = mem[rp[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wp[AW-1:0]] <= rx_byte;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wp       <= '0;
         rp       <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wp <= wp + 1'b1;
         if (rd)    rp <= rp + 1'b1;
         if (wr_en && full && !rd) overflow <= 1'b1;
      end
   end

   logic [8:0]          tkey [MAX_KEYS];
   logic [MAX_KEYS-1:0] tval;
   logic                cur_ext;
   logic                is_brk;
   logic [8:0]          key_in;
   logic                hit;
   logic                free;
   logic [IW-1:0]       hit_idx;
   logic [IW-1:0]       free_idx;
   logic                ign;
   logic                done;
   st_t                 nst;

   assign cur_ext = (st == EXT) || (st == EXT_BRK);
   assign is_brk  = (st == BRK) || (st == EXT_BRK);
   assign key_in  = {cur_ext, head};
   assign ign     = (head == 8'h00) || (head == 8'hAA) || (head == 8'hEE)
                 || (head == 8'hFA) || (head == 8'hFE);

   always_comb begin
      hit      = 1'b0;
      free     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      shift    = 1'b0;
      ctrl     = 1'b0;
      alt      = 1'b0;
      for (int i = 0; i < MAX_KEYS; i++) begin
         if (tval[i]) begin
            if (tkey[i] == key_in) begin
               hit     = 1'b1;
               hit_idx = IW'(i);
            end
            if (tkey[i] == 9'h012 || tkey[i] == 9'h059) shift = 1'b1;
            if (tkey[i][7:0] == 8'h14) ctrl = 1'b1;
            if (tkey[i][7:0] == 8'h11) alt  = 1'b1;
         end
      end
      for (int i = MAX_KEYS - 1; i >= 0; i--) begin
         if (!tval[i]) begin
            free     = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   always_comb begin
      done = 1'b0;
      nst  = st;
      unique case (st)
         IDLE: begin
            if      (head == 8'hE0) nst = EXT;
            else if (head == 8'hF0) nst = BRK;
            else if (!ign)          done = 1'b1;
         end
         EXT: begin
            if (head == 8'hF0) nst = EXT_BRK;
            else               done = 1'b1;
         end
         BRK, EXT_BRK: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         st         <= IDLE;
         ev_valid   <= 1'b0;
         ev_code    <= '0;
         ev_ext     <= 1'b0;
         ev_break   <= 1'b0;
         held_count <= '0;
         caps       <= 1'b0;
         tval       <= '0;
         for (int i = 0; i < MAX_KEYS; i++) tkey[i] <= '0;
      end else if (st == EMIT) begin
         if (ev_ready) begin
            ev_valid <= 1'b0;
            st       <= IDLE;
         end
      end else if (rd) begin
         if (!done) begin
            st <= nst;
         end else if (!is_brk && hit && FILT) begin
            st <= IDLE;
         end else begin
            st       <= EMIT;
            ev_valid <= 1'b1;
            ev_code  <= head;
            ev_ext   <= cur_ext;
            ev_break <= is_brk;
            if (is_brk && hit) begin
               tval[hit_idx] <= 1'b0;
               held_count    <= held_count - CW'(1);
            end
            if (!is_brk && !hit && free) begin
               tval[free_idx] <= 1'b1;
               tkey[free_idx] <= key_in;
               held_count     <= held_count + CW'(1);
            end
            if (!is_brk && key_in == 9'h058) caps <= ~caps;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed and randomized checks of ps2_key_tracker against a
// key-event reference model (set of held keys, expected event list).
module tb_ps2_key_tracker;

   localparam int FD = 8;
   localparam int MK = 6;
   localparam int TO = 300;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       ev_valid;
   logic       ev_ready = 1'b0;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic [2:0] held_count;
   logic       shift, ctrl, alt, caps, overflow, frame_err;

   ps2_key_tracker #(.FIFO_DEPTH(FD), .MAX_KEYS(MK), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
      .ev_ext(ev_ext), .ev_break(ev_break), .held_count(held_count),
      .shift(shift), .ctrl(ctrl), .alt(alt), .caps(caps),
      .overflow(overflow), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int rmode = 0;
   int fe_pulses = 0;
   int fe_cycles = 0;
   logic fe_prev = 1'b0;

   logic [9:0] exp_q[$];
   logic [9:0] obs_q[$];
   logic [8:0] held[$];
   logic       m_caps = 1'b0;
   logic       pend_ext = 1'b0;
   logic       pend_brk = 1'b0;
   logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h1C, 8'h12, 8'h59,
                             8'h14, 8'h11, 8'h58, 8'h23, 8'hAA};

   initial forever begin
      @(posedge clk);
      #2;
      if (rmode == 2) ev_ready = 1'($urandom_range(0, 1));
      else            ev_ready = (rmode == 1);
   end

   always @(negedge clk) begin
      if (ev_valid && ev_ready) obs_q.push_back({ev_ext, ev_break, ev_code});
      if (frame_err) fe_cycles++;
      if (frame_err && !fe_prev) fe_pulses++;
      fe_prev <= frame_err;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, o, e);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
      return {1'b1, (~^b) ^ bad, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] fr, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = fr[i];
         #100 ps2_clk = 1'b0;
         #200 ps2_clk = 1'b1;
         #100;
      end
   endtask

   task automatic model_key(input logic [8:0] k, input logic brk);
      int idx = -1;
      foreach (held[i]) if (held[i] == k) idx = i;
      if (brk) begin
         exp_q.push_back({k[8], 1'b1, k[7:0]});
         if (idx >= 0) held.delete(idx);
      end else begin
`ifdef KEY_TYPEMATIC_FILTER_EN
         if (idx >= 0) return;
`endif
         exp_q.push_back({k[8], 1'b0, k[7:0]});
         if (idx < 0 && held.size() < MK) held.push_back(k);
         if (k == 9'h058) m_caps = ~m_caps;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (!pend_ext && !pend_brk && b == 8'hE0) pend_ext = 1'b1;
      else if (!pend_brk && b == 8'hF0) pend_brk = 1'b1;
      else if (!pend_ext && !pend_brk &&
               (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE)) ;
      else begin
         model_key({pend_ext, b}, pend_brk);
         pend_ext = 1'b0;
         pend_brk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(frame(b, 1'b0), 11);
      model_byte(b);
   endtask

   task automatic model_reset();
      held.delete();
      exp_q.delete();
      obs_q.delete();
      m_caps = 1'b0;
      pend_ext = 1'b0;
      pend_brk = 1'b0;
   endtask

   task automatic drain();
      repeat (150) @(negedge clk);
   endtask

   task automatic check_events(input string tag);
      chk({tag, "_n"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk({tag, "_ev"}, obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_state(input string tag);
      logic s = 1'b0, c = 1'b0, a = 1'b0;
      foreach (held[i]) begin
         if (held[i] == 9'h012 || held[i] == 9'h059) s = 1'b1;
         if (held[i][7:0] == 8'h14) c = 1'b1;
         if (held[i][7:0] == 8'h11) a = 1'b1;
      end
      chk({tag, "_held"}, held_count, held.size());
      chk({tag, "_shift"}, shift, s);
      chk({tag, "_ctrl"}, ctrl, c);
      chk({tag, "_alt"}, alt, a);
      chk({tag, "_caps"}, caps, m_caps);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, ev_valid, 0);
      chk({tag, "_code"}, {ev_ext, ev_break, ev_code}, 0);
      chk({tag, "_held"}, held_count, 0);
      chk({tag, "_mods"}, {shift, ctrl, alt, caps}, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_ferr"}, frame_err, 0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check_zero("reset");
      clr = 1'b0;
      repeat (10) @(negedge clk);
      rmode = 1;

      send_byte(8'h1C); drain();
      check_events("make1c"); check_state("make1c");
      send_byte(8'hF0); send_byte(8'h1C); drain();
      check_events("brk1c"); check_state("brk1c");

      send_byte(8'hE0); send_byte(8'h75); drain();
      check_events("ext_make"); check_state("ext_make");
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); drain();
      check_events("ext_brk"); check_state("ext_brk");

      send_byte(8'h12);
      for (int i = 0; i < 3; i++) send_byte(8'h1C);
      drain();
      check_events("typematic"); check_state("typematic");
      chk("typ_held2", held_count, 2);
      chk("typ_shift", shift, 1);

      rmode = 2;
      send_byte(8'hE0); send_byte(8'h14); send_byte(8'h11);
      send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
      drain();
      check_events("mods"); check_state("mods");
      foreach (pool[i]) if (i >= 2) begin
         send_byte(8'hF0); send_byte(pool[i]);
      end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
      drain();
      check_events("release"); check_state("release");

      fe_pulses = 0; fe_cycles = 0;
      send_bits(frame(8'h1C, 1'b1), 11); drain();
      chk("par_pulses", fe_pulses, 1);
      chk("par_cycles", fe_cycles, 1);
      check_events("par_noev");
      send_byte(8'h2C); drain();
      check_events("par_after");

      fe_pulses = 0;
      send_bits(frame(8'h33, 1'b0), 4);
      repeat (TO + 60) @(negedge clk);
      chk("tmo_noerr", fe_pulses, 0);
      send_byte(8'h2D); drain();
      check_events("tmo_after");
      chk("tmo_noerr2", fe_pulses, 0);

      for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i));
      drain();
      check_events("max7"); check_state("max7");

      for (int i = 0; i < 60; i++) send_byte(pool[$urandom_range(0, 9)]);
      send_byte(8'h1C);
      drain();
      check_events("rand"); check_state("rand");
      chk("rand_ovf", overflow, 0);

      clr = 1'b1; #20 clr = 1'b0;
      model_reset();
      rmode = 0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < FD + 1; i++) send_byte(8'h15 + 8'(i));
      drain();
      chk("ovf_before", overflow, 0);
      send_bits(frame(8'h1E, 1'b0), 11); drain();
      chk("ovf_set", overflow, 1);
      chk("ovf_stall", {ev_valid, ev_ext, ev_break, ev_code}, {3'b100, 8'h15});
      chk("ovf_held", held_count, 1);
      rmode = 1; drain();
      check_events("ovf_drain"); check_state("ovf_drain");

      rmode = 0;
      send_byte(8'h2B); drain();
      chk("pre_clr_valid", ev_valid, 1);
      send_bits(frame(8'h34, 1'b0), 5);
      clr = 1'b1;
      #1;
      check_zero("clr_mid");
      #30 clr = 1'b0;
      model_reset();
      rmode = 1;
      repeat (10) @(negedge clk);
      send_byte(8'h1C); drain();
      check_events("post_clr"); check_state("post_clr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
